uart_tx_serializer: RTL

//  Transmit-side serializer of the UART: pops bytes from the TX FIFO and shifts them out on stx_pad_o
//  as start/data/parity/stop frames, driven by the 16x baud enable strobe.

---
 rtl/uart_tx_serializer_pkg.sv | 41 ++++
 rtl/uart_tx_tick_cnt.sv | 36 +++
 rtl/uart_tx_serializer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_pkg.sv
// Purpose : shared types for the UART transmit serializer (state codes, LCR fields, parity helper).
// Latency : n/a (types and a combinational helper only).
// Backpressure: n/a.
package uart_tx_serializer_pkg;

   // State codes are visible on the debug read mux, so the values are fixed.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_POP    = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } tx_state_e;

   // LCR bit positions
   localparam int LCR_STB   = 2;
   localparam int LCR_PE    = 3;
   localparam int LCR_EPS   = 4;
   localparam int LCR_STICK = 5;
   localparam int LCR_BRK   = 6;

   // Frame configuration latched from lcr[5:0]; field order matches the LCR bits.
   typedef struct packed {
      logic       stick;
      logic       eps;
      logic       pe;
      logic       stb;
      logic [1:0] wlen;   // word length minus 5
   } tx_cfg_t;

   // Parity bit over the wlen+5 low data bits only.
   function automatic logic tx_parity(input logic [7:0] data, input tx_cfg_t cfg);
      logic [7:0] mask;
      mask = 8'hFF >> (2'd3 - cfg.wlen);
      if (cfg.stick)
         return ~cfg.eps;
      return cfg.eps ? ^(data & mask) : ~^(data & mask);
   endfunction

endpackage

// File: rtl/uart_tx_tick_cnt.sv
// Purpose : counts baud enable strobes within one bit period, flags bit end and half-bit end.
// Latency : flags are combinational on the strobe that completes the (half) bit.
// Backpressure: none; clr_i holds the count at zero.
// Ports: clk, rst (async high), clr_i (sync clear), enable_i (strobe) -> bit_end_o, half_end_o.
module uart_tx_tick_cnt #(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic enable_i,
   output logic bit_end_o,
   output logic half_end_o
);
   localparam int CW = $clog2(OVERSAMPLE);

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_end_o  = enable_i && (cnt_q == CW'(OVERSAMPLE - 1));
   assign half_end_o = enable_i && (cnt_q == CW'(OVERSAMPLE / 2 - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || bit_end_o)
         cnt_d = '0;
      else if (enable_i)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_tx_serializer.sv
// Purpose : pops bytes from the TX FIFO and shifts start/data/parity/stop frames onto stx_pad_o.
// Latency : pop one clk after a non-empty FIFO is seen in idle; start bit follows the pop clk.
// Backpressure: tf_count is sampled only in idle; no new byte is taken until the frame completes.
// Ports: clk, wb_rst_i (async high), enable (16x strobe), lcr, tf_data_out, tf_count, tx_reset
//        -> tf_pop, stx_pad_o, tstate, tx_busy [, frame_cnt when UART_TX_FRAME_CNT_EN is defined].
module uart_tx_serializer
   import uart_tx_serializer_pkg::*;
#(
   parameter int FIFO_CNT_W = 5,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  clk,
   input  logic                  wb_rst_i,
   input  logic                  enable,
   input  logic [7:0]            lcr,
   input  logic [7:0]            tf_data_out,
   input  logic [FIFO_CNT_W-1:0] tf_count,
   input  logic                  tx_reset,
   output logic                  tf_pop,
   output logic                  stx_pad_o,
   output logic [2:0]            tstate,
`ifdef UART_TX_FRAME_CNT_EN
   output logic [7:0]            frame_cnt,
`endif
   output logic                  tx_busy
);
   tx_state_e  state_q, state_d;
   tx_cfg_t    cfg_q, cfg_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       par_q, par_d;
   logic       stx_q, line_d;
   logic       pop_q, busy_q;
   logic       tick_clr, bit_end, half_end, stop_end;
   logic       unused_lcr7;

   assign unused_lcr7 = lcr[7];

   // Counter idles at zero so the start bit always gets a full OVERSAMPLE strobes.
   assign tick_clr = (state_q == S_IDLE) || (state_q == S_POP) || tx_reset;

   uart_tx_tick_cnt #(.OVERSAMPLE(OVERSAMPLE)) u_tick (
      .clk       (clk),
      .rst       (wb_rst_i),
      .clr_i     (tick_clr),
      .enable_i  (enable),
      .bit_end_o (bit_end),
      .half_end_o(half_end)
   );

   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      par_d     = par_q;
      line_d    = 1'b1;
      stop_end  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tf_count != '0)
               state_d = S_POP;
         end
         S_POP: begin
            shift_d = tf_data_out;
            cfg_d   = tx_cfg_t'(lcr[5:0]);
            par_d   = tx_parity(tf_data_out, tx_cfg_t'(lcr[5:0]));
            state_d = S_START;
            line_d  = 1'b0;
         end
         S_START: begin
            line_d = 1'b0;
            if (bit_end) begin
               state_d = S_DATA;
               line_d  = shift_q[0];
            end
         end
         S_DATA: begin
            line_d = shift_q[0];
            if (bit_end) begin
               if (bit_cnt_q == 3'(cfg_q.wlen) + 3'd4) begin
                  bit_cnt_d = '0;
                  state_d   = cfg_q.pe ? S_PARITY : S_STOP;
                  line_d    = cfg_q.pe ? par_q : 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = shift_q >> 1;
                  line_d    = shift_d[0];
               end
            end
         end
         S_PARITY: begin
            line_d = par_q;
            if (bit_end) begin
               state_d = S_STOP;
               line_d  = 1'b1;
            end
         end
         S_STOP: begin
            // bit_cnt_q counts completed stop bits; 1.5 stop ends mid second bit.
            if (!cfg_q.stb)
               stop_end = bit_end;
            else if (cfg_q.wlen == 2'd0)
               stop_end = (bit_cnt_q == 3'd1) && half_end;
            else
               stop_end = (bit_cnt_q == 3'd1) && bit_end;
            if (bit_end)
               bit_cnt_d = bit_cnt_q + 3'd1;
            if (stop_end) begin
               bit_cnt_d = '0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= S_IDLE;
         cfg_q     <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         stx_q     <= 1'b1;
         pop_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else if (tx_reset) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         stx_q     <= ~lcr[LCR_BRK];
         pop_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         par_q     <= par_d;
         // Break overrides the line but never stalls the FSM.
         stx_q     <= lcr[LCR_BRK] ? 1'b0 : line_d;
         pop_q     <= (state_d == S_POP);
         busy_q    <= (state_d != S_IDLE);
      end
   end

`ifdef UART_TX_FRAME_CNT_EN
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i)
         frame_cnt <= '0;
      else if (tx_reset)
         frame_cnt <= '0;
      else if (stop_end)
         frame_cnt <= frame_cnt + 8'd1;
   end
`endif

   assign tstate    = state_q;
   assign stx_pad_o = stx_q;
   assign tx_busy   = busy_q;
   // A flush landing on the pop clk must not also decrement the FIFO.
   assign tf_pop    = pop_q & ~tx_reset;
endmodule
